// File: rtl/seg_pkg.sv
// Shared definitions for the scanned 7-segment display decoder: segment
// patterns, digit-enable encodings and the capture FSM state encoding.
package seg_pkg;

  // Capture FSM states. EMIT is a single-cycle publish state.
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    GOT_U = 2'd1,
    GOT_T = 2'd2,
    EMIT  = 2'd3
  } state_t;

  // Digit-enable encodings (active-low enables).
  localparam logic [1:0] DX_UNITS   = 2'b10;
  localparam logic [1:0] DX_TENS    = 2'b01;
  localparam logic [1:0] DX_BLANK   = 2'b11;
  localparam logic [1:0] DX_ILLEGAL = 2'b00;

  // Nibble reported for a segment pattern that is not a decimal digit.
  localparam logic [3:0] BCD_BAD = 4'hE;

  // Segment patterns {g,f,e,d,c,b,a} for digits 0..9, active-high.
  localparam logic [6:0] SEG_CODE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD nibble decoder. Unknown patterns
// yield BCD_BAD with ok low.
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       ok
);

  // Table lookup against the shared segment code list.
  always_comb begin
    digit = BCD_BAD;
    ok    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (seg == SEG_CODE[i]) begin
        digit = 4'(i);
        ok    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers a two-digit BCD value from a multiplexed 7-segment display bus.
// Inputs are synchronized, a digit is accepted once per stable dwell, and
// a frame is published once both a units and a tens digit are captured.
// Handshake: O_valid is a one-cycle strobe with no backpressure; O_bcd is
// updated in the same cycle and holds until the next O_valid. O_change is
// only ever high together with O_valid.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter bit SEG_ACT_LOW    = 1'b0
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic [6:0] I_led,
  input  logic [1:0] I_dx,
  output logic [7:0] O_bcd,
  output logic       O_valid,
  output logic       O_change,
  output logic       O_err,
  output logic       O_stall,
  output logic [1:0] dbg_state
);

  localparam int             SW         = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0]  STABLE_MAX = SW'(STABLE_CYCLES);
  localparam int             TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_MAX    = TW'(TIMEOUT_CYCLES);

  // {dx, led} through two flops; reset value is the blank display.
  logic [8:0] sync1, sync2;

  logic [SW-1:0] stab_cnt, stab_nxt;
  logic          fresh, fresh_nxt;

  state_t     state, state_nxt;
  logic [3:0] units_q, tens_q, units_nxt, tens_nxt;
  logic [TW-1:0] tmo_cnt;

  logic [1:0] cur_dx;
  logic [6:0] cur_led;
  logic [6:0] seg_in;
  logic [3:0] dec_digit;
  logic       dec_ok;
  logic       acc_u, acc_t, acc_bad_dx, bad_seg;

  assign cur_dx  = sync2[8:7];
  assign cur_led = sync2[6:0];
  assign seg_in  = SEG_ACT_LOW ? ~cur_led : cur_led;

  seg7_to_bcd u_dec (
    .seg   (seg_in),
    .digit (dec_digit),
    .ok    (dec_ok)
  );

  // Two-flop input synchronizer.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {I_dx, I_led};
      sync2 <= sync1;
    end
  end

  // Next dwell count for the value about to enter sync2, and whether
  // that count reaches the threshold for the first time in this dwell.
  always_comb begin
    if (sync1 != sync2) begin
      stab_nxt = SW'(1);
    end else if (stab_cnt == STABLE_MAX) begin
      stab_nxt = stab_cnt;
    end else begin
      stab_nxt = stab_cnt + SW'(1);
    end
    fresh_nxt = (stab_nxt == STABLE_MAX) &&
                ((stab_cnt != STABLE_MAX) || (sync1 != sync2));
  end

  // Dwell counter and one-shot acceptance strobe aligned with sync2.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      stab_cnt <= '0;
      fresh    <= 1'b0;
    end else begin
      stab_cnt <= stab_nxt;
      fresh    <= fresh_nxt;
    end
  end

  assign acc_u      = fresh && (cur_dx == DX_UNITS);
  assign acc_t      = fresh && (cur_dx == DX_TENS);
  assign acc_bad_dx = fresh && (cur_dx == DX_ILLEGAL);
  assign bad_seg    = (acc_u || acc_t) && !dec_ok;

  // Capture FSM: collect one units and one tens digit, then publish.
  // EMIT treats a same-cycle acceptance like SYNC so no digit is lost.
  always_comb begin
    state_nxt = state;
    units_nxt = units_q;
    tens_nxt  = tens_q;
    case (state)
      SYNC, EMIT: begin
        state_nxt = SYNC;
        if (acc_u) begin
          units_nxt = dec_digit;
          state_nxt = GOT_U;
        end else if (acc_t) begin
          tens_nxt  = dec_digit;
          state_nxt = GOT_T;
        end
      end
      GOT_U: begin
        if (acc_u) begin
          units_nxt = dec_digit;
        end else if (acc_t) begin
          tens_nxt  = dec_digit;
          state_nxt = EMIT;
        end
      end
      GOT_T: begin
        if (acc_t) begin
          tens_nxt  = dec_digit;
        end else if (acc_u) begin
          units_nxt = dec_digit;
          state_nxt = EMIT;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // FSM state, captured digits, published frame and sticky error.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state    <= SYNC;
      units_q  <= '0;
      tens_q   <= '0;
      O_bcd    <= '0;
      O_valid  <= 1'b0;
      O_change <= 1'b0;
      O_err    <= 1'b0;
    end else begin
      state   <= state_nxt;
      units_q <= units_nxt;
      tens_q  <= tens_nxt;
      if (state_nxt == EMIT) begin
        O_bcd    <= {tens_nxt, units_nxt};
        O_valid  <= 1'b1;
        O_change <= ({tens_nxt, units_nxt} != O_bcd);
      end else begin
        O_valid  <= 1'b0;
        O_change <= 1'b0;
      end
      if (acc_bad_dx || bad_seg) begin
        O_err <= 1'b1;
      end
    end
  end

  // Frame timeout: cleared on entry to EMIT, saturating otherwise.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      tmo_cnt <= '0;
    end else if (state_nxt == EMIT) begin
      tmo_cnt <= '0;
    end else if ((state != EMIT) && (tmo_cnt != TMO_MAX)) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign O_stall   = (tmo_cnt == TMO_MAX);
  assign dbg_state = state;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed latency/boundary
// sequences, a vector table of frames and a randomized dwell stream checked
// against a dwell-level reference model.
module tb_seg_scan_decoder;
  import seg_pkg::*;

  localparam int STABLE = 4;
  localparam int TMO    = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] led = 7'h7F;
  logic [1:0] dx  = 2'b11;
  logic [7:0] O_bcd;
  logic       O_valid, O_change, O_err, O_stall;
  logic [1:0] dbg_state;

  seg_scan_decoder #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO),
    .SEG_ACT_LOW    (1'b0)
  ) dut (
    .I_clk     (clk),
    .I_rst     (rst),
    .I_led     (led),
    .I_dx      (dx),
    .O_bcd     (O_bcd),
    .O_valid   (O_valid),
    .O_change  (O_change),
    .O_err     (O_err),
    .O_stall   (O_stall),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];   // {change, bcd} frames predicted by the model
  logic [8:0] obs_q[$];   // {change, bcd} frames seen on the outputs

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Record every published frame.
  always @(posedge clk) begin
    #1;
    if (O_valid === 1'b1) obs_q.push_back({O_change, O_bcd});
  end

  // ---------------- reference model (dwell level) ----------------
  logic [3:0] m_u, m_t;
  bit         m_hu, m_ht, m_err;
  logic [7:0] m_last;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'h3F; 1: seg_of = 7'h06; 2: seg_of = 7'h5B; 3: seg_of = 7'h4F;
      4: seg_of = 7'h66; 5: seg_of = 7'h6D; 6: seg_of = 7'h7D; 7: seg_of = 7'h07;
      8: seg_of = 7'h7F; default: seg_of = 7'h6F;
    endcase
  endfunction

  function automatic logic [3:0] ref_dec(input logic [6:0] p);
    ref_dec = 4'hE;
    for (int d = 0; d < 10; d++) if (seg_of(d) == p) ref_dec = 4'(d);
  endfunction

  task automatic model_reset();
    m_hu = 0; m_ht = 0; m_err = 0; m_last = 8'h00; m_u = 0; m_t = 0;
  endtask

  // A dwell of len cycles is accepted as a digit only if len >= STABLE.
  task automatic model_dwell(input logic [1:0] d, input logic [6:0] l, input int len);
    logic [3:0] v;
    logic [7:0] frame;
    if (len < STABLE) return;
    v = ref_dec(l);
    case (d)
      2'b00: m_err = 1;
      2'b10: begin m_u = v; m_hu = 1; if (v == 4'hE) m_err = 1; end
      2'b01: begin m_t = v; m_ht = 1; if (v == 4'hE) m_err = 1; end
      default: ;
    endcase
    if (m_hu && m_ht) begin
      frame = {m_t, m_u};
      exp_q.push_back({frame != m_last, frame});
      m_last = frame;
      m_hu = 0; m_ht = 0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic dwell(input logic [1:0] d, input logic [6:0] l, input int len);
    model_dwell(d, l, len);
    dx = d; led = l;
    repeat (len) begin @(posedge clk); #1; end
  endtask

  task automatic probe(input logic [1:0] d, input logic [6:0] l, input int len,
                       output int lat, output int nval, output logic [7:0] b,
                       output logic c, output logic st);
    model_dwell(d, l, len);
    dx = d; led = l;
    lat = -1; nval = 0; b = '0; c = 1'b0; st = 1'b0;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      if (O_valid === 1'b1) begin
        nval++;
        if (lat < 0) begin lat = k; b = O_bcd; c = O_change; st = O_stall; end
      end
    end
  endtask

  task automatic assert_reset();
    rst = 1'b1; dx = 2'b11; led = 7'h7F;
    model_reset();
    #2;
  endtask

  task automatic release_reset();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [6:0] u_seg;
    logic [6:0] t_seg;
    logic [7:0] exp_bcd;
    logic       exp_err;
  } vec_t;
  vec_t tbl[7];

  int lat, nval;
  logic [7:0] b;
  logic c, st;
  int r;
  logic [1:0] rd;
  logic [6:0] rl;

  initial begin
    tbl[0] = '{7'h3F, 7'h06, 8'h10, 1'b0};
    tbl[1] = '{7'h5B, 7'h4F, 8'h32, 1'b0};
    tbl[2] = '{7'h66, 7'h6D, 8'h54, 1'b0};
    tbl[3] = '{7'h7D, 7'h07, 8'h76, 1'b0};
    tbl[4] = '{7'h7F, 7'h6F, 8'h98, 1'b0};
    tbl[5] = '{7'h3F, 7'h3F, 8'h00, 1'b0};
    tbl[6] = '{7'h3F, 7'h12, 8'hE0, 1'b1};

    // Reset state
    #3;
    assert_reset();
    check("rst_bcd", O_bcd, 8'h00);
    check("rst_valid", O_valid, 1'b0);
    check("rst_change", O_change, 1'b0);
    check("rst_err", O_err, 1'b0);
    check("rst_stall", O_stall, 1'b0);
    check("rst_state", dbg_state, SYNC);
    release_reset();

    // First frame 00 after reset: valid but no change
    dwell(2'b10, 7'h3F, 10);
    probe(2'b01, 7'h3F, 10, lat, nval, b, c, st);
    check("first00_nval", nval, 1);
    check("first00_bcd", b, 8'h00);
    check("first00_chg", c, 1'b0);

    // Units 4F then tens 06 -> 13, latency 2 sync + STABLE dwell
    dwell(2'b10, 7'h4F, 10);
    probe(2'b01, 7'h06, 10, lat, nval, b, c, st);
    check("f13_lat", lat, 2 + STABLE);
    check("f13_nval", nval, 1);
    check("f13_bcd", b, 8'h13);
    check("f13_chg", c, 1'b1);

    // Same frame again -> valid, no change
    dwell(2'b10, 7'h4F, 10);
    probe(2'b01, 7'h06, 10, lat, nval, b, c, st);
    check("rep13_nval", nval, 1);
    check("rep13_bcd", b, 8'h13);
    check("rep13_chg", c, 1'b0);

    // Units dwell of STABLE-1 cycles is not accepted
    dwell(2'b10, 7'h3F, STABLE - 1);
    probe(2'b01, 7'h06, 10, lat, nval, b, c, st);
    check("short_nval", nval, 0);
    probe(2'b10, 7'h5B, 10, lat, nval, b, c, st);
    check("short_bcd", b, 8'h12);
    check("short_nval2", nval, 1);

    // Table of frames, ending with an undecodable tens pattern
    for (int i = 0; i < 7; i++) begin
      dwell(2'b10, tbl[i].u_seg, 6);
      dwell(2'b01, tbl[i].t_seg, 6);
      dwell(2'b11, 7'h7F, 4);
      check($sformatf("tbl%0d_bcd", i), O_bcd, tbl[i].exp_bcd);
      check($sformatf("tbl%0d_err", i), O_err, tbl[i].exp_err);
    end

    // Stall after a long blank period, cleared in the EMIT cycle
    dwell(2'b11, 7'h7F, TMO + 5);
    check("stall_set", O_stall, 1'b1);
    dwell(2'b10, 7'h66, 10);
    check("stall_hold", O_stall, 1'b1);
    probe(2'b01, 7'h6D, 10, lat, nval, b, c, st);
    check("stall_emit", st, 1'b0);
    check("stall_bcd", b, 8'h54);
    check("err_sticky", O_err, 1'b1);

    // Reset while holding a units digit
    dwell(2'b10, 7'h4F, 10);
    check("gotu_state", dbg_state, GOT_U);
    assert_reset();
    check("rst2_state", dbg_state, SYNC);
    check("rst2_err", O_err, 1'b0);
    check("rst2_bcd", O_bcd, 8'h00);
    release_reset();
    probe(2'b01, 7'h5B, 10, lat, nval, b, c, st);
    check("rst2_early", nval, 0);
    probe(2'b10, 7'h66, 10, lat, nval, b, c, st);
    check("rst2_nval", nval, 1);
    check("rst2_f24", b, 8'h24);
    check("rst2_chg", c, 1'b1);

    // Randomized dwell stream against the model
    for (int n = 0; n < 150; n++) begin
      r  = int'($urandom_range(0, 19));
      rd = (r < 8) ? 2'b10 : (r < 16) ? 2'b01 : (r < 19) ? 2'b11 : 2'b00;
      if ($urandom_range(0, 7) == 0) rl = 7'($urandom_range(0, 127));
      else                           rl = seg_of(int'($urandom_range(0, 9)));
      if ({rd, rl} == {dx, led}) rl = rl ^ 7'h40;
      dwell(rd, rl, int'($urandom_range(1, 8)));
    end
    if ({dx, led} == {2'b11, 7'h7F}) dwell(2'b11, 7'h7E, 10);
    else                             dwell(2'b11, 7'h7F, 10);
    check("rand_err", O_err, m_err);

    // Every frame of the run, in order
    check("frame_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("frame%0d", i), obs_q[i], exp_q[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
